alaghi_adder_tree: RTL and testbench

- Parametrised N-input scaled stochastic adder built as a binary tree of toggle-based (Alaghi-style) pairwise adders.
- Output stream probability is the mean of the N input stream probabilities.
- Optional per-level pipelining and a valid qualifier, so it can sit between SNG banks and downstream stochastic arithmetic at full clock rate.
- Successor to the single-pair adder: generalised in input count, with selectable latency, stream gating and synchronous clear.

---
 rtl/alaghi_adder_tree.sv | 92 +++++++++
 tb/tb_alaghi_adder_tree.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alaghi_adder_tree.sv
// N-input scaled stochastic adder: a binary tree of toggle-based pairwise adders.
// Root output stream probability is the mean of the input stream probabilities.
module alaghi_adder_tree #(
   parameter int unsigned           NUM_INPUTS = 8,
   parameter int unsigned           PIPELINE   = 1,
   parameter logic [NUM_INPUTS-2:0] RESET_SEED = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  in_valid,
   input  logic [NUM_INPUTS-1:0] in_bits,
   output logic                  out_bit,
   output logic                  out_valid
);

   localparam int unsigned LEVELS = $clog2(NUM_INPUTS);
   localparam int unsigned NODES  = NUM_INPUTS - 1;

   // All per-node vectors use heap numbering: root = 0, children of n = 2n+1, 2n+2.
   logic [NODES-1:0]  tog_q, tog_d;
   logic [NODES-1:0]  stage_q, stage_d;
   logic [LEVELS-1:0] vld_q, vld_d;
   logic [NODES-1:0]  node_o;
   logic [LEVELS:0]   vld_chain;

   assign vld_chain = {vld_q, in_valid};

   always_comb begin
      int unsigned base;
      int unsigned n;
      logic        a;
      logic        b;
      logic        qual;
      tog_d   = tog_q;
      stage_d = stage_q;
      vld_d   = vld_q;
      node_o  = '0;
      base    = 0;
      n       = 0;
      a       = 1'b0;
      b       = 1'b0;
      qual    = 1'b0;
      // Leaves first, so each parent sees its children already evaluated.
      for (int unsigned l = 0; l < LEVELS; l++) begin
         qual = (PIPELINE != 0) ? vld_chain[l] : in_valid;
         base = (NUM_INPUTS >> (l + 1)) - 1;
         for (int unsigned j = 0; j < (NUM_INPUTS >> (l + 1)); j++) begin
            n = base + j;
            if (l == 0) begin
               a = in_bits[2*j];
               b = in_bits[2*j+1];
            end else if (PIPELINE != 0) begin
               a = stage_q[2*n+1];
               b = stage_q[2*n+2];
            end else begin
               a = node_o[2*n+1];
               b = node_o[2*n+2];
            end
            node_o[n] = (a ^ b) ? tog_q[n] : b;
            if (qual && (a ^ b)) begin
               tog_d[n] = ~tog_q[n];
            end
            if (qual) begin
               stage_d[n] = node_o[n];
            end
         end
         vld_d[l] = qual;
      end
      if (clr) begin
         tog_d   = RESET_SEED;
         stage_d = '0;
         vld_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tog_q   <= RESET_SEED;
         stage_q <= '0;
         vld_q   <= '0;
      end else begin
         tog_q   <= tog_d;
         stage_q <= stage_d;
         vld_q   <= vld_d;
      end
   end

   assign out_bit   = (PIPELINE != 0) ? stage_q[0] : node_o[0];
   assign out_valid = (PIPELINE != 0) ? vld_q[LEVELS-1] : (in_valid & rst);

endmodule

// File: tb/tb_alaghi_adder_tree.sv
// Scoreboard bench for alaghi_adder_tree: three instances (N=4 piped, N=8 comb, N=8 piped
// with all-ones seed) driven by directed streams; a negedge monitor pops expected bits.
module tb_alaghi_adder_tree;

   localparam int ND = 3;
   localparam int unsigned NIN [ND] = '{4, 8, 8};
   localparam int unsigned LAT [ND] = '{2, 0, 3};
   localparam logic [6:0]  SEED [ND] = '{7'h00, 7'h35, 7'h7F};

   typedef struct {
      logic        b;
      int unsigned cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rst_s       [ND];
   logic       clr_s       [ND];
   logic       in_valid_s  [ND];
   logic [7:0] in_bits_s   [ND];
   logic       out_bit_w   [ND];
   logic       out_valid_w [ND];

   exp_t       sb [ND][$];
   logic [6:0] mt [ND];
   int         ones_out [ND];
   int         vectors = 0;
   int         miscompares = 0;

   alaghi_adder_tree #(.NUM_INPUTS(4), .PIPELINE(1), .RESET_SEED(3'b000)) u_n4p (
      .clk(clk), .rst(rst_s[0]), .clr(clr_s[0]), .in_valid(in_valid_s[0]),
      .in_bits(in_bits_s[0][3:0]), .out_bit(out_bit_w[0]), .out_valid(out_valid_w[0]));

   alaghi_adder_tree #(.NUM_INPUTS(8), .PIPELINE(0), .RESET_SEED(7'h35)) u_n8c (
      .clk(clk), .rst(rst_s[1]), .clr(clr_s[1]), .in_valid(in_valid_s[1]),
      .in_bits(in_bits_s[1]), .out_bit(out_bit_w[1]), .out_valid(out_valid_w[1]));

   alaghi_adder_tree #(.NUM_INPUTS(8), .PIPELINE(1), .RESET_SEED(7'h7F)) u_n8p (
      .clk(clk), .rst(rst_s[2]), .clr(clr_s[2]), .in_valid(in_valid_s[2]),
      .in_bits(in_bits_s[2]), .out_bit(out_bit_w[2]), .out_valid(out_valid_w[2]));

   // Reference tree: level by level, node output = disagree ? toggle : right input.
   task automatic tree_step(input int unsigned n_in, input logic [7:0] bits,
                            input logic [6:0] ti, output logic [6:0] to, output logic y);
      logic [7:0]  cur;
      logic [7:0]  nxt;
      int unsigned w;
      int unsigned base;
      cur = bits;
      to  = ti;
      w   = n_in;
      while (w > 1) begin
         base = w / 2 - 1;
         nxt  = '0;
         for (int unsigned j = 0; j < w / 2; j++) begin
            if (cur[2*j] != cur[2*j+1]) begin
               nxt[j]      = to[base+j];
               to[base+j]  = ~to[base+j];
            end else begin
               nxt[j] = cur[2*j+1];
            end
         end
         cur = nxt;
         w   = w / 2;
      end
      y = cur[0];
   endtask

   task automatic check(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // One input cycle; a clr driven last cycle has now taken effect, so flush and reseed.
   task automatic cycle_in(input int d, input logic v, input logic [7:0] bits, input logic c,
                           input logic hand_en, input logic hand_bit);
      logic       y;
      logic [6:0] tn;
      exp_t       e;
      @(posedge clk);
      #1;
      if (clr_s[d]) begin
         sb[d].delete();
         mt[d] = SEED[d];
      end
      in_valid_s[d] = v;
      in_bits_s[d]  = bits;
      clr_s[d]      = c;
      if (v && !c) begin
         tree_step(NIN[d], bits, mt[d], tn, y);
         mt[d] = tn;
         e.b   = hand_en ? hand_bit : y;
         e.cyc = cyc;
         sb[d].push_back(e);
      end
   endtask

   task automatic drain(input int d);
      int k;
      k = 0;
      while (sb[d].size() != 0 && k < 20) begin
         cycle_in(d, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
         k++;
      end
      check($sformatf("drain_pending_dut%0d", d), sb[d].size(), 0);
      sb[d].delete();
   endtask

   task automatic async_reset(input int d);
      @(posedge clk);
      #2;
      rst_s[d] = 1'b0;
      #1;
      check($sformatf("async_rst_out_valid_dut%0d", d), int'(out_valid_w[d]), 0);
      check($sformatf("async_rst_out_bit_dut%0d", d), int'(out_bit_w[d]), 0);
      sb[d].delete();
      mt[d]         = SEED[d];
      in_valid_s[d] = 1'b0;
      clr_s[d]      = 1'b0;
      @(posedge clk);
      #3;
      rst_s[d] = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < ND; d++) begin
         if (out_valid_w[d] === 1'b1) begin
            if (out_bit_w[d] === 1'b1) ones_out[d]++;
            vectors++;
            if (sb[d].size() == 0) begin
               miscompares++;
               $display("FAIL spurious_valid_dut%0d cyc=%0d: out_valid=1, required 0", d, cyc);
            end else begin
               e = sb[d].pop_front();
               if (out_bit_w[d] !== e.b || cyc != e.cyc + LAT[d]) begin
                  miscompares++;
                  $display("FAIL out_dut%0d: got bit=%b at cyc %0d, required bit=%b at cyc %0d",
                           d, out_bit_w[d], cyc, e.b, e.cyc + LAT[d]);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1);
   end

   initial begin
      for (int d = 0; d < ND; d++) begin
         rst_s[d]      = 1'b0;
         clr_s[d]      = 1'b0;
         in_valid_s[d] = 1'b0;
         in_bits_s[d]  = 8'h00;
         mt[d]         = SEED[d];
         ones_out[d]   = 0;
      end
      #12;
      for (int d = 0; d < ND; d++)
         check($sformatf("reset_out_valid_dut%0d", d), int'(out_valid_w[d]), 0);
      check("reset_out_bit_dut0", int'(out_bit_w[0]), 0);
      check("reset_out_bit_dut2", int'(out_bit_w[2]), 0);
      #10;
      for (int d = 0; d < ND; d++) rst_s[d] = 1'b1;

      fork
         begin : p_n4p
            // all ones in -> all ones out; all zeros -> zeros; 0101 -> alternating 0,1
            for (int i = 0; i < 20; i++) cycle_in(0, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b1);
            drain(0);
            cycle_in(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 20; i++) cycle_in(0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
            drain(0);
            cycle_in(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            cycle_in(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            ones_out[0] = 0;
            for (int i = 0; i < 100; i++) cycle_in(0, 1'b1, 8'h05, 1'b0, 1'b1, 1'(i % 2));
            drain(0);
            check("ones_0101_of_100", ones_out[0], 50);
         end
         begin : p_n8c
            logic [15:0] lf [8];
            logic [7:0]  bits;
            logic        v;
            int          ones_in;
            int          diff;
            ones_in = 0;
            for (int i = 0; i < 8; i++) lf[i] = 16'hACE1 + 16'(i * 4951);
            ones_out[1] = 0;
            for (int c = 0; c < 256; c++) begin
               for (int i = 0; i < 8; i++) begin
                  lf[i]   = {lf[i][14:0], lf[i][15] ^ lf[i][13] ^ lf[i][12] ^ lf[i][10]};
                  bits[i] = (int'(lf[i][7:0]) < 32 * (i + 1));
               end
               v = (c % 16 != 15);
               if (v) ones_in += $countones(bits);
               cycle_in(1, v, bits, 1'b0, 1'b0, 1'b0);
            end
            drain(1);
            diff = 8 * ones_out[1] - ones_in;
            vectors++;
            if (diff > 24 || diff < -24) begin
               miscompares++;
               $display("FAIL root_error_bound: ones_out=%0d ones_in=%0d, required |8*out-in|<=24",
                        ones_out[1], ones_in);
            end
         end
         begin : p_n8p
            logic v;
            for (int i = 0; i < 30; i++) begin
               v = (i % 3 == 0) || (i == 10);
               cycle_in(2, v, 8'($urandom), 1'(i == 10), 1'b0, 1'b0);
            end
            for (int i = 0; i < 6; i++) cycle_in(2, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
            async_reset(2);
            for (int i = 0; i < 30; i++) cycle_in(2, 1'(i % 3 == 0), 8'($urandom), 1'b0, 1'b0, 1'b0);
            drain(2);
         end
      join

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
